seq_mult_unit: RTL

SEQ_MULT_UNIT -- requirements
Module: seq_mult_unit

---
 rtl/seq_mult_unit_pkg.sv | 20 ++
 rtl/seq_mult_unit_mux2.sv | 14 +
 rtl/seq_mult_unit.sv | 107 ++++++++++
 3 files changed

// File: rtl/seq_mult_unit_pkg.sv
// Shared definitions for the sequential shift-add multiplier: FSM states,
// default operand width and iteration-counter sizing.
package seq_mult_unit_pkg;

    localparam int unsigned SEQ_MULT_N_DEFAULT = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter must hold 0..N-1; a one-bit operand still needs a one-bit counter.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 32'd2) ? 32'd1 : $clog2(n);
    endfunction

    localparam int unsigned CNT_W_DEFAULT = cnt_width(SEQ_MULT_N_DEFAULT);

endpackage

// File: rtl/seq_mult_unit_mux2.sv
// Two-input word multiplexer used to choose between the summed and the
// unmodified working register.
module seq_mult_unit_mux2 #(
    parameter int unsigned WIDTH = 11
) (
    input  logic [WIDTH-1:0] d0_i,
    input  logic [WIDTH-1:0] d1_i,
    input  logic             s_i,
    output logic [WIDTH-1:0] y_o
);

    assign y_o = s_i ? d1_i : d0_i;

endmodule

// File: rtl/seq_mult_unit.sv
// Unsigned shift-add multiplier: one partial-product step per CALC cycle,
// result registered on entry to DONE and held until the next completion.
module seq_mult_unit
    import seq_mult_unit_pkg::*;
#(
    parameter int unsigned N = SEQ_MULT_N_DEFAULT,
    parameter int unsigned W = 2 * N + 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic [2*N-1:0] product,
    output logic           busy,
    output logic           done
);

    localparam int unsigned CW = cnt_width(N);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [N-1:0]    a_q;
    logic [W-1:0]    p_q;
    logic [W-1:0]    p_d;
    logic [2*N-1:0]  product_q;
    logic            busy_q;
    logic            done_q;

    logic [N:0]      sum_s;
    logic [W-1:0]    summed_s;
    logic [W-1:0]    mux_s;

    // Upper-half add keeps its carry in the top bit so all-ones operands cannot overflow.
    always_comb begin
        sum_s    = p_q[W-1:N] + {1'b0, a_q};
        summed_s = {sum_s, p_q[N-1:0]};
    end

    seq_mult_unit_mux2 #(
        .WIDTH(W)
    ) u_mux2 (
        .d0_i(p_q),
        .d1_i(summed_s),
        .s_i (p_q[0]),
        .y_o (mux_s)
    );

    // Shift the selected value right by one, zero-filling the top bit.
    always_comb begin
        p_d = mux_s >> 1'b1;
    end

    // Control FSM plus every datapath register; outputs are registered here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= {CW{1'b0}};
            a_q       <= {N{1'b0}};
            p_q       <= {W{1'b0}};
            product_q <= {(2*N){1'b0}};
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q     <= a;
                        p_q     <= {1'b0, {N{1'b0}}, b};
                        cnt_q   <= {CW{1'b0}};
                        busy_q  <= 1'b1;
                        state_q <= CALC;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                CALC: begin
                    p_q   <= p_d;
                    cnt_q <= cnt_q + CW'(1'b1);
                    if (cnt_q == CNT_LAST) begin
                        product_q <= p_d[2*N-1:0];
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= DONE;
                    end else begin
                        busy_q    <= 1'b1;
                        done_q    <= 1'b0;
                        state_q   <= CALC;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign product = product_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule
